// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter for the FP register-file write port.
// Also holds the pending-write scoreboard used for issue hazard stalls.
module fp_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req_FPU,
  input  logic [ADDR_WIDTH-1:0] addr_FPU,
  input  logic [DATA_WIDTH-1:0] data_FPU,
  output logic                  gnt_FPU,
  input  logic                  req_LSU,
  input  logic [ADDR_WIDTH-1:0] addr_LSU,
  input  logic [DATA_WIDTH-1:0] data_LSU,
  output logic                  gnt_LSU,
  input  logic                  req_MOV,
  input  logic [ADDR_WIDTH-1:0] addr_MOV,
  input  logic [DATA_WIDTH-1:0] data_MOV,
  output logic                  gnt_MOV,
  output logic                  wr_En,
  output logic [ADDR_WIDTH-1:0] wr_Addr,
  output logic [DATA_WIDTH-1:0] wr_Data,
  input  logic                  rsv_En,
  input  logic [ADDR_WIDTH-1:0] rsv_Addr,
  input  logic [ADDR_WIDTH-1:0] chk_AddrA,
  input  logic [ADDR_WIDTH-1:0] chk_AddrB,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic [NUM_REGS-1:0]   busy_Mask,
  output logic                  addr_Err
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {
    LAST_FPU,
    LAST_LSU,
    LAST_MOV
  } last_e;

  last_e last_q, last_d;

  logic [2:0]            req;
  logic [2:0]            gnt;
  logic                  any_gnt;
  logic                  sel_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign req = {req_MOV, req_LSU, req_FPU};

  // Search starts at the source after the last winner.
  always_comb begin
    gnt    = '0;
    last_d = last_q;
    if (!Rst) begin
      unique case (last_q)
        LAST_FPU: begin
          if (req[1])      gnt[1] = 1'b1;
          else if (req[2]) gnt[2] = 1'b1;
          else if (req[0]) gnt[0] = 1'b1;
        end
        LAST_LSU: begin
          if (req[2])      gnt[2] = 1'b1;
          else if (req[0]) gnt[0] = 1'b1;
          else if (req[1]) gnt[1] = 1'b1;
        end
        default: begin
          if (req[0])      gnt[0] = 1'b1;
          else if (req[1]) gnt[1] = 1'b1;
          else if (req[2]) gnt[2] = 1'b1;
        end
      endcase
    end
    unique case (1'b1)
      gnt[0]:  last_d = LAST_FPU;
      gnt[1]:  last_d = LAST_LSU;
      gnt[2]:  last_d = LAST_MOV;
      default: last_d = last_q;
    endcase
  end

  assign gnt_FPU = gnt[0];
  assign gnt_LSU = gnt[1];
  assign gnt_MOV = gnt[2];
  assign any_gnt = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt[0]: begin
        sel_addr = addr_FPU;
        sel_data = data_FPU;
      end
      gnt[1]: begin
        sel_addr = addr_LSU;
        sel_data = data_LSU;
      end
      gnt[2]: begin
        sel_addr = addr_MOV;
        sel_data = data_MOV;
      end
      default: ;
    endcase
  end

  assign sel_ok = sel_addr < LIMIT;

  // Reservation applied after the clear: the newer instruction owns the reg.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt && sel_ok)
      busy_d[sel_addr[IDX_W-1:0]] = 1'b0;
    if (rsv_En && (rsv_Addr < LIMIT))
      busy_d[rsv_Addr[IDX_W-1:0]] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_q   <= LAST_MOV;
      busy_q   <= '0;
      wr_En    <= 1'b0;
      wr_Addr  <= '0;
      wr_Data  <= '0;
      addr_Err <= 1'b0;
    end else begin
      last_q   <= last_d;
      busy_q   <= busy_d;
      wr_En    <= any_gnt & sel_ok;
      addr_Err <= any_gnt & ~sel_ok;
      if (any_gnt && sel_ok) begin
        wr_Addr <= sel_addr;
        wr_Data <= sel_data;
      end
    end
  end

  assign busy_Mask = busy_q;
  assign busy_A = (chk_AddrA < LIMIT) & busy_q[chk_AddrA[IDX_W-1:0]];
  assign busy_B = (chk_AddrB < LIMIT) & busy_q[chk_AddrB[IDX_W-1:0]];

endmodule
